spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI bridge, in the sclk domain.
- Consumes the bridge's byte stream (byte_sync, data_in) and decodes two-byte frames: a command byte, then a data byte.
- Issues single-cycle write and read strobes to the peripheral register file.
- Returns read data on data_out, which the bridge shifts out on MISO during the second byte.

Parameters:
- ADDR_W, 6, register address width; must be <= 7. Uses data_in[ADDR_W-1:0] of the command byte.
- NUM_REGS, 48, number of implemented registers. Addresses >= NUM_REGS are invalid.

Ports:
- sclk  in  1  SPI clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cs_n  in  1  chip select from master, active-low; frame boundary.
- byte_sync  in  1  one-sclk pulse from bridge: data_in holds a complete byte.
- data_in  in  8  received byte from bridge.
- data_out  out  8  byte for bridge to transmit next.
- reg_addr  out  ADDR_W  register file address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  write strobe, one sclk cycle.
- reg_re  out  1  read strobe, one sclk cycle.
- reg_rdata  in  8  combinational read data for reg_addr.
- err  out  1  sticky invalid-access flag.

Behaviour:
- Command byte format: bit7 = rw (1 write, 0 read); bits[6:ADDR_W] ignored; bits[ADDR_W-1:0] = addr.
- State machine:
  - CMD (reset state) and DATA.
  - A byte is "accepted" at a posedge sclk where byte_sync=1 and cs_n=0.
- CMD:
  - On accept: latch cmd_rw <= data_in[7] and cmd_addr <= data_in[ADDR_W-1:0], then go to DATA.
  - If the command is a read: reg_re=1 for the cycle after accept, with reg_addr=cmd_addr.
- Read data path (the bridge loads data_out on the sclk negedge while byte_sync is high):
  - data_out is combinational: when state=CMD and byte_sync=1 and data_in[7]=0, reg_addr is driven from data_in[ADDR_W-1:0] and data_out = reg_rdata, or 8'h00 if the address is invalid.
  - Otherwise data_out = rdata_q.
  - rdata_q captures that value on accept.
  - Read latency from command byte to MISO: zero bytes; data appears in the second byte.
- DATA:
  - On accept, if cmd_rw=1 and cmd_addr < NUM_REGS: reg_we=1 for exactly the next cycle, with reg_addr=cmd_addr and reg_wdata=data_in registered.
  - If cmd_addr >= NUM_REGS (read or write): no strobe, err <= 1, read returns 8'h00.
  - Read data byte: the received dummy byte is discarded.
  - Return to CMD.
- reg_addr = cmd_addr outside the combinational read window.
- cs_n=1 sampled at any posedge:
  - State -> CMD; pending strobes cleared; cmd_rw/cmd_addr held.
  - A frame aborted in DATA performs no write.
- A byte_sync with cs_n=1 is ignored.
- err is cleared only by reset. A write of 8'hFF to address NUM_REGS-1 does NOT clear it.
- Reset values: state=CMD, data_out=8'h00, rdata_q=8'h00, reg_addr=0, reg_wdata=8'h00, reg_we=0, reg_re=0, err=0, cmd_rw=0, cmd_addr=0.
- reg_we and reg_re are never asserted in the same cycle.
- Reset mid-frame: immediate return to reset values; the next byte is treated as a command.

Optional Feature:
- SPI_CMD_AUTOINC_EN
- Defined:
  - In DATA, after each accepted data byte, stay in DATA and increment cmd_addr (wraps from NUM_REGS-1 to 0), enabling bursts until cs_n rises.
  - For reads, the next register is fetched combinationally on the accept of each data byte and captured into rdata_q, with a reg_re pulse.
- Undefined: single data byte per command; return to CMD after it.

Test Plan:
- Reset released, no sclk -> all outputs at reset values, err=0, data_out=8'h00.
- Frame 8'h85, 8'h3C (write addr 5) -> reg_we one cycle after the 2nd byte_sync with reg_addr=5 and reg_wdata=8'h3C; reg_re never high.
- Frame 8'h05, 8'h00 with reg[5]=8'hA7 -> data_out=8'hA7 during the 1st byte_sync; MISO shifts 10100111 on byte 2; reg_re pulses once.
- Write 8'hB5 (addr 53 >= 48), 8'h11 -> no reg_we, err=1 and stays 1 through a later valid write.
- Command 8'h82, cs_n raised before the data byte, then new frame 8'h03, 8'h00 -> no write to addr 2; addr 3 is read normally.
- SPI_CMD_AUTOINC_EN: 8'h80, 8'h01, 8'h02, 8'h03 in one frame -> writes reg0=1, reg1=2, reg2=3. Without the macro only reg0 is written and 8'h02 is decoded as a read command for addr 2.

Source files
------------

// File: rtl/spi_cmd_decoder_if.sv
// Bridge-side byte stream and register-file bus of the SPI command decoder.
interface spi_cmd_decoder_if #(
    parameter int ADDR_W = 6
);
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              err;

    modport slave (
        input  cs_n, byte_sync, data_in, reg_rdata,
        output data_out, reg_addr, reg_wdata, reg_we, reg_re, err
    );

    modport master (
        output cs_n, byte_sync, data_in, reg_rdata,
        input  data_out, reg_addr, reg_wdata, reg_we, reg_re, err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Two-byte SPI command decoder (command byte, then data byte) driving a register file.
// Define SPI_CMD_AUTOINC_EN to keep streaming data bytes at incrementing addresses until cs_n rises.
module spi_cmd_decoder #(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 48
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    spi_cmd_decoder_if.slave        bus
);

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_rw_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [7:0]        rdata_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_we_q;
    logic              reg_re_q;
    logic              err_q;

    logic              accept;
    logic [ADDR_W-1:0] in_addr;
    logic              fetch_window;
    logic [ADDR_W-1:0] fetch_addr;
    logic [7:0]        fetch_data;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    assign accept  = bus.byte_sync & ~bus.cs_n;
    assign in_addr = bus.data_in[ADDR_W-1:0];

`ifdef SPI_CMD_AUTOINC_EN
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] wr_addr_q;

    assign next_addr = (cmd_addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cmd_addr_q + 1'b1;
`endif

    // The bridge loads data_out on the negedge while byte_sync is high, so the
    // register fetch for the next MISO byte must be combinational.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fetch_window = (state_q == ST_CMD) && bus.byte_sync && !bus.data_in[7];
        fetch_addr   = in_addr;
`ifdef SPI_CMD_AUTOINC_EN
        if ((state_q == ST_DATA) && bus.byte_sync && !cmd_rw_q) begin
            fetch_window = 1'b1;
            fetch_addr   = next_addr;
        end
`endif
    end

    assign fetch_data   = addr_ok(fetch_addr) ? bus.reg_rdata : 8'h00;
    assign bus.data_out = fetch_window ? fetch_data : rdata_q;

`ifdef SPI_CMD_AUTOINC_EN
    // cmd_addr has already advanced while a burst write strobe is out.
    assign bus.reg_addr = fetch_window ? fetch_addr : (reg_we_q ? wr_addr_q : cmd_addr_q);
`else
    assign bus.reg_addr = fetch_window ? fetch_addr : cmd_addr_q;
`endif

    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.err       = err_q;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_CMD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.cs_n) begin
            state_d = ST_CMD;
        end else if (accept) begin
`ifdef SPI_CMD_AUTOINC_EN
            state_d = ST_DATA;
`else
            state_d = (state_q == ST_CMD) ? ST_DATA : ST_CMD;
`endif
        end
    end

    // Strobes default low each cycle, so cs_n high (no accept) also clears them.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            rdata_q     <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            err_q       <= 1'b0;
`ifdef SPI_CMD_AUTOINC_EN
            wr_addr_q   <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            if (accept) begin
                if (state_q == ST_CMD) begin
                    cmd_rw_q   <= bus.data_in[7];
                    cmd_addr_q <= in_addr;
                    if (!bus.data_in[7]) begin
                        rdata_q  <= fetch_data;
                        reg_re_q <= addr_ok(in_addr);
                    end
                end else begin
                    if (!addr_ok(cmd_addr_q)) err_q <= 1'b1;
                    if (cmd_rw_q) begin
                        reg_we_q    <= addr_ok(cmd_addr_q);
                        reg_wdata_q <= bus.data_in;
                    end
`ifdef SPI_CMD_AUTOINC_EN
                    wr_addr_q  <= cmd_addr_q;
                    cmd_addr_q <= next_addr;
                    if (!cmd_rw_q) begin
                        rdata_q  <= fetch_data;
                        reg_re_q <= addr_ok(next_addr);
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed testbench for spi_cmd_decoder: emulates the SPI bridge and a 48-entry register file.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 48;

    logic sclk   = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    int we_cnt = 0;
    int re_cnt = 0;
    int both_cnt = 0;

    logic [7:0] regs [64];

    logic [7:0]        s_miso;
    logic              s_we, s_re;
    logic [ADDR_W-1:0] s_addr;
    logic [7:0]        s_wdata;

    spi_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_cmd_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always begin
        #5;
        if (clk_en) sclk = ~sclk;
    end

    assign bus.reg_rdata = (int'(bus.reg_addr) < NUM_REGS) ? regs[bus.reg_addr] : 8'h00;

    // Register-file model plus strobe counters.
    always @(posedge sclk) begin
        if (bus.reg_we) begin
            regs[bus.reg_addr] <= bus.reg_wdata;
            we_cnt++;
        end
        if (bus.reg_re) re_cnt++;
        if (bus.reg_we && bus.reg_re) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One byte slot of 8 sclk cycles; byte_sync high for one cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge sclk);
        bus.data_in   = b;
        bus.byte_sync = 1'b1;
        #1 s_miso = bus.data_out;
        @(negedge sclk);
        bus.byte_sync = 1'b0;
        #1;
        s_we    = bus.reg_we;
        s_re    = bus.reg_re;
        s_addr  = bus.reg_addr;
        s_wdata = bus.reg_wdata;
        repeat (6) @(negedge sclk);
    endtask

    task automatic frame_start();
        @(negedge sclk);
        bus.cs_n = 1'b0;
    endtask

    task automatic frame_end();
        @(negedge sclk);
        bus.cs_n = 1'b1;
        repeat (2) @(negedge sclk);
    endtask

    int we0, re0;

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        regs[2] = 8'h11;
        regs[3] = 8'h5A;
        regs[5] = 8'hA7;
        bus.cs_n      = 1'b1;
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'h00;

        // Reset state with no sclk activity.
        #2;
        check("rst data_out", bus.data_out, 8'h00);
        check("rst reg_addr", bus.reg_addr, 0);
        check("rst reg_wdata", bus.reg_wdata, 8'h00);
        check("rst we/re", {bus.reg_we, bus.reg_re}, 2'b00);
        check("rst err", bus.err, 1'b0);
        rst_n = 1'b1;
        #3;
        check("post-rst err", bus.err, 1'b0);
        clk_en = 1'b1;
        repeat (3) @(negedge sclk);

        // Write 0x3C to addr 5.
        we0 = we_cnt; re0 = re_cnt;
        frame_start();
        send_byte(8'h85);
        check("wr cmd no strobe", {s_we, s_re}, 2'b00);
        send_byte(8'h3C);
        check("wr reg_we", s_we, 1'b1);
        check("wr reg_addr", s_addr, 5);
        check("wr reg_wdata", s_wdata, 8'h3C);
        frame_end();
        check("wr single pulse", we_cnt - we0, 1);
        check("wr no reg_re", re_cnt - re0, 0);
        regs[5] = 8'hA7;

        // Read addr 5: data appears during command byte_sync and persists for byte 2.
        we0 = we_cnt; re0 = re_cnt;
        frame_start();
        send_byte(8'h05);
        check("rd miso byte1", s_miso, 8'hA7);
        check("rd reg_re", s_re, 1'b1);
        check("rd reg_addr", s_addr, 5);
        send_byte(8'h00);
        check("rd miso byte2", s_miso, 8'hA7);
        check("rd no we", s_we, 1'b0);
        frame_end();
        check("rd one re pulse", re_cnt - re0, 1);
        check("rd no writes", we_cnt - we0, 0);

        // Write to invalid addr 53: no strobe, err sticky.
        we0 = we_cnt;
        frame_start();
        send_byte(8'hB5);
        send_byte(8'h11);
        check("inv wr no we", s_we, 1'b0);
        frame_end();
        check("inv wr err", bus.err, 1'b1);
        check("inv wr count", we_cnt - we0, 0);

        // Valid write of 0xFF to NUM_REGS-1 leaves err set.
        frame_start();
        send_byte(8'hAF);
        send_byte(8'hFF);
        check("last wr we", s_we, 1'b1);
        check("last wr addr", s_addr, 47);
        frame_end();
        check("err sticky", bus.err, 1'b1);

        // Read of invalid addr 48 returns zero, no reg_re.
        re0 = re_cnt;
        frame_start();
        send_byte(8'h30);
        check("inv rd miso", s_miso, 8'h00);
        send_byte(8'h00);
        check("inv rd miso byte2", s_miso, 8'h00);
        frame_end();
        check("inv rd no re", re_cnt - re0, 0);

        // Aborted write to addr 2, then a normal read of addr 3.
        we0 = we_cnt;
        frame_start();
        send_byte(8'h82);
        frame_end();
        send_byte(8'h44);
        check("abort no write", we_cnt - we0, 0);
        frame_start();
        send_byte(8'h03);
        check("post-abort rd miso", s_miso, 8'h5A);
        check("post-abort rd addr", s_addr, 3);
        send_byte(8'h00);
        frame_end();
        check("post-abort no write", we_cnt - we0, 0);
        check("reg2 intact", regs[2], 8'h11);

        // Reset mid-frame: next byte is a command.
        frame_start();
        send_byte(8'h85);
        @(negedge sclk);
        rst_n = 1'b0;
        #1;
        check("midrst reg_addr", bus.reg_addr, 0);
        check("midrst data_out", bus.data_out, 8'h00);
        check("midrst err cleared", bus.err, 1'b0);
        @(negedge sclk);
        rst_n = 1'b1;
        we0 = we_cnt;
        send_byte(8'h05);
        check("midrst cmd rd", s_miso, 8'hA7);
        send_byte(8'h00);
        frame_end();
        check("midrst no write", we_cnt - we0, 0);

        // Burst frame 80,01,02,03.
        we0 = we_cnt; re0 = re_cnt;
        frame_start();
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h02);
`ifdef SPI_CMD_AUTOINC_EN
        check("burst byte2 we", s_we, 1'b1);
        check("burst byte2 addr", s_addr, 1);
`else
        check("single cmd rd miso", s_miso, 8'h11);
        check("single cmd re", s_re, 1'b1);
        check("single cmd rd addr", s_addr, 2);
`endif
        send_byte(8'h03);
        frame_end();
        check("burst reg0", regs[0], 8'h01);
`ifdef SPI_CMD_AUTOINC_EN
        check("burst writes", we_cnt - we0, 3);
        check("burst reg1", regs[1], 8'h02);
        check("burst reg2", regs[2], 8'h03);
`else
        check("single writes", we_cnt - we0, 1);
        check("single re", re_cnt - re0, 1);
        check("single reg2", regs[2], 8'h11);
`endif

        check("we/re never overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
